// File: rtl/hazard_detect_unit.sv
// Decode-stage hazard detector: load-use, branch flush and full-freeze codes for the pipeline controller.
// hazType is zero-latency combinational; no backpressure, the controller acts on the code the same cycle.
module hazard_detect_unit #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rt,
   input  logic             ex_memRead,
   input  logic             ex_mdStart,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic [1:0]       hazType,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} md_state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

   md_state_t  state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       md_freeze;
   logic       load_use;
   logic       freeze;

   assign load_use = ex_memRead && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign freeze   = mem_busy || md_freeze;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // MD_WAIT is held past the count while memory is busy so the lingering ex_mdStart cannot restart it
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (ex_mdStart) begin
               state_nxt = MD_WAIT;
               cnt_nxt   = MD_INIT;
            end
         end
         MD_WAIT: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else if (!mem_busy) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      md_freeze = 1'b0;
      hazType   = 2'b00;
      md_busy   = (state == MD_WAIT);
      case (state)
         IDLE:    md_freeze = ex_mdStart;
         MD_WAIT: md_freeze = (cnt != 4'd0);
         default: md_freeze = 1'b0;
      endcase
      if (reset) begin
         hazType = 2'b00;
      end else if (freeze) begin
         hazType = 2'b11;
      end else if (branch_taken) begin
         hazType = 2'b10;
      end else if (load_use) begin
         hazType = 2'b01;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazType[0] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if ((hazType == 2'b10) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule
